// File: rtl/mic_pkg.sv
// Shared types and constants for the Mic-1 style datapath.
// No logic of its own; pure declarations.
// No flow control; consumers import what they need.
package mic_pkg;

    // Default datapath shape
    localparam int NBITS_DEF = 32;
    localparam int NC_DEF    = 9;
    localparam int BW_DEF    = 4;
    localparam int MIW_DEF   = 2 + 6 + NC_DEF + 3 + BW_DEF;

    // Microinstruction field offsets for the default shape (LSB of each field)
    localparam int MI_BSEL_LSB  = 0;
    localparam int MI_MEM_LSB   = BW_DEF;
    localparam int MI_CWR_LSB   = BW_DEF + 3;
    localparam int MI_ALU_LSB   = MI_CWR_LSB + NC_DEF;
    localparam int MI_SHIFT_LSB = MI_ALU_LSB + 6;

    // Bit positions inside the 3-bit mem field
    localparam int MEM_FETCH_BIT = 0;
    localparam int MEM_RD_BIT    = 1;
    localparam int MEM_WR_BIT    = 2;

    // Bit positions inside the 6-bit ALU field {F0,F1,ENA,ENB,INVA,INC}
    localparam int ALU_F0   = 5;
    localparam int ALU_F1   = 4;
    localparam int ALU_ENA  = 3;
    localparam int ALU_ENB  = 2;
    localparam int ALU_INVA = 1;
    localparam int ALU_INC  = 0;

    // Commonly used ALU function codes
    localparam logic [5:0] ALU_FN_A       = 6'b011000;
    localparam logic [5:0] ALU_FN_B       = 6'b010100;
    localparam logic [5:0] ALU_FN_A_ADD_B = 6'b111100;
    localparam logic [5:0] ALU_FN_B_SUB_A = 6'b111111;
    localparam logic [5:0] ALU_FN_B_INC   = 6'b110101;
    localparam logic [5:0] ALU_FN_ZERO    = 6'b010000;
    localparam logic [5:0] ALU_FN_ONE     = 6'b110001;

    // B-bus sources; codes above B_OPC drive zero
    typedef enum logic [3:0] {
        B_MDR  = 4'd0,
        B_PC   = 4'd1,
        B_MBR  = 4'd2,
        B_MBRU = 4'd3,
        B_SP   = 4'd4,
        B_LV   = 4'd5,
        B_CPP  = 4'd6,
        B_TOS  = 4'd7,
        B_OPC  = 4'd8
    } b_sel_e;

    // C-bus write-enable bit indices
    typedef enum logic [3:0] {
        C_MAR = 4'd0,
        C_MDR = 4'd1,
        C_PC  = 4'd2,
        C_SP  = 4'd3,
        C_LV  = 4'd4,
        C_CPP = 4'd5,
        C_TOS = 4'd6,
        C_OPC = 4'd7,
        C_H   = 4'd8
    } c_bit_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RW    = 2'd1,
        FETCH = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mic_mem_ctrl.sv
// Serialises MAR/MDR read-write and PC/MBR fetch requests; derives the stall term.
// Request visible the cycle after issue; returns to IDLE the edge an ack is seen.
// Holds mem_req until ack; stalls dependent microinstructions while busy.
module mic_mem_ctrl
    import mic_pkg::*;
#(
    parameter int BW = BW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_i,
    input  logic          rd_i,
    input  logic          fetch_i,
    input  logic [BW-1:0] b_sel_i,
    input  logic          c_ptr_i,
    input  logic          ack_i,
    output logic          stall_o,
    output logic          req_o,
    output logic          we_o,
    output logic          fetch_o,
    output logic          ld_mdr_o,
    output logic          ld_mbr_o
);

    mem_state_e state_q, state_d;
    logic       we_q, we_d;
    logic       fq_q, fq_d;
    logic       dep;

    // State, latched direction and queued-fetch bit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            fq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            fq_q    <= fq_d;
        end
    end

    // Next state and request outputs; stall is 0 in IDLE so any op seen there is issued
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        fq_d     = fq_q;
        req_o    = 1'b0;
        we_o     = 1'b0;
        fetch_o  = 1'b0;
        ld_mdr_o = 1'b0;
        ld_mbr_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_i || rd_i) begin
                    state_d = RW;
                    we_d    = wr_i;
                    fq_d    = fetch_i;
                end else if (fetch_i) begin
                    state_d = FETCH;
                end
            end
            RW: begin
                req_o = 1'b1;
                we_o  = we_q;
                if (ack_i) begin
                    ld_mdr_o = !we_q;
                    fq_d     = 1'b0;
                    state_d  = fq_q ? FETCH : IDLE;
                end
            end
            FETCH: begin
                req_o   = 1'b1;
                fetch_o = 1'b1;
                if (ack_i) begin
                    ld_mbr_o = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Anything touching memory, MDR/MBR or the address/data registers depends on the transfer
    assign dep = wr_i || rd_i || fetch_i || c_ptr_i ||
                 (b_sel_i == BW'(B_MDR)) || (b_sel_i == BW'(B_MBR)) || (b_sel_i == BW'(B_MBRU));
    assign stall_o = (state_q != IDLE) && dep;

endmodule

// File: rtl/mic_datapath_stall.sv
// Mic-1 datapath: register file, A/B/C buses, ALU, shifter, N/Z flags, memory port.
// Single-cycle execute; memory ops take at least two cycles after issue.
// Stalls the microinstruction while a dependent memory transfer is outstanding.
module mic_datapath_stall
    import mic_pkg::*;
#(
    parameter  int NBITS = NBITS_DEF,
    parameter  int NC    = NC_DEF,
    parameter  int BW    = BW_DEF,
    localparam int MIW   = 2 + 6 + NC + 3 + BW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MIW-1:0]   microinst,
    output logic             stall,
    output logic             n,
    output logic             z,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_fetch,
    output logic [NBITS-1:0] mem_addr,
    output logic [NBITS-1:0] mem_wdata,
    input  logic [NBITS-1:0] mem_rdata,
    input  logic             mem_ack
);

    localparam int B_LO = 0;
    localparam int M_LO = BW;
    localparam int C_LO = BW + 3;
    localparam int A_LO = C_LO + NC;
    localparam int S_LO = A_LO + 6;

    logic [1:0]       shift;
    logic [5:0]       alu_fn;
    logic [NC-1:0]    c_wr;
    logic [2:0]       mem_op;
    logic [BW-1:0]    b_sel;

    logic [NBITS-1:0] mar_q, mdr_q, pc_q, sp_q, lv_q, cpp_q, tos_q, opc_q, h_q;
    logic [7:0]       mbr_q;
    logic             n_q, z_q;

    logic [NBITS-1:0] b_bus, a_op, b_op, alu_out, c_bus;
    logic             ld_mdr, ld_mbr;

    assign shift  = microinst[S_LO +: 2];
    assign alu_fn = microinst[A_LO +: 6];
    assign c_wr   = microinst[C_LO +: NC];
    assign mem_op = microinst[M_LO +: 3];
    assign b_sel  = microinst[B_LO +: BW];

    mic_mem_ctrl #(.BW(BW)) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .wr_i     (mem_op[MEM_WR_BIT]),
        .rd_i     (mem_op[MEM_RD_BIT]),
        .fetch_i  (mem_op[MEM_FETCH_BIT]),
        .b_sel_i  (b_sel),
        .c_ptr_i  (c_wr[C_MAR] || c_wr[C_MDR] || c_wr[C_PC]),
        .ack_i    (mem_ack),
        .stall_o  (stall),
        .req_o    (mem_req),
        .we_o     (mem_we),
        .fetch_o  (mem_fetch),
        .ld_mdr_o (ld_mdr),
        .ld_mbr_o (ld_mbr)
    );

    // B-bus source select
    always_comb begin
        b_bus = '0;
        case (b_sel)
            BW'(B_MDR):  b_bus = mdr_q;
            BW'(B_PC):   b_bus = pc_q;
            BW'(B_MBR):  b_bus = {{(NBITS-8){mbr_q[7]}}, mbr_q};
            BW'(B_MBRU): b_bus = {{(NBITS-8){1'b0}}, mbr_q};
            BW'(B_SP):   b_bus = sp_q;
            BW'(B_LV):   b_bus = lv_q;
            BW'(B_CPP):  b_bus = cpp_q;
            BW'(B_TOS):  b_bus = tos_q;
            BW'(B_OPC):  b_bus = opc_q;
            default:     b_bus = '0;
        endcase
    end

    // ALU: operand gating/inversion then F0/F1 function; carry out discarded
    always_comb begin
        a_op = alu_fn[ALU_ENA] ? h_q : '0;
        if (alu_fn[ALU_INVA]) a_op = ~a_op;
        b_op = alu_fn[ALU_ENB] ? b_bus : '0;
        case ({alu_fn[ALU_F0], alu_fn[ALU_F1]})
            2'b00:   alu_out = a_op & b_op;
            2'b01:   alu_out = a_op | b_op;
            2'b10:   alu_out = ~b_op;
            default: alu_out = a_op + b_op + NBITS'(alu_fn[ALU_INC]);
        endcase
    end

    // Shifter: byte shift left first, then arithmetic shift right by one
    always_comb begin
        c_bus = alu_out;
        if (shift[1]) c_bus = c_bus << 8;
        if (shift[0]) c_bus = {c_bus[NBITS-1], c_bus[NBITS-1:1]};
    end

    // Register file, MBR and flags; memory returns never collide with an executing write
    always_ff @(posedge clk) begin
        if (reset) begin
            mar_q <= '0;
            mdr_q <= '0;
            pc_q  <= '0;
            sp_q  <= '0;
            lv_q  <= '0;
            cpp_q <= '0;
            tos_q <= '0;
            opc_q <= '0;
            h_q   <= '0;
            mbr_q <= '0;
            n_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            if (!stall) begin
                if (c_wr[C_MAR]) mar_q <= c_bus;
                if (c_wr[C_MDR]) mdr_q <= c_bus;
                if (c_wr[C_PC])  pc_q  <= c_bus;
                if (c_wr[C_SP])  sp_q  <= c_bus;
                if (c_wr[C_LV])  lv_q  <= c_bus;
                if (c_wr[C_CPP]) cpp_q <= c_bus;
                if (c_wr[C_TOS]) tos_q <= c_bus;
                if (c_wr[C_OPC]) opc_q <= c_bus;
                if (c_wr[C_H])   h_q   <= c_bus;
                n_q <= alu_out[NBITS-1];
                z_q <= (alu_out == '0);
            end
            if (ld_mdr) mdr_q <= mem_rdata;
            if (ld_mbr) mbr_q <= mem_rdata[7:0];
        end
    end

    assign n         = n_q;
    assign z         = z_q;
    assign mem_addr  = mem_fetch ? pc_q : mar_q;
    assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mic_datapath_stall.sv
module tb_mic_datapath_stall;
    import mic_pkg::*;

    localparam int MIW = MIW_DEF;

    localparam logic [2:0] M_WR = 3'b100;
    localparam logic [2:0] M_RD = 3'b010;
    localparam logic [2:0] M_FE = 3'b001;

    localparam logic [8:0] CW_MAR = 9'h001;
    localparam logic [8:0] CW_MDR = 9'h002;
    localparam logic [8:0] CW_PC  = 9'h004;
    localparam logic [8:0] CW_SP  = 9'h008;
    localparam logic [8:0] CW_TOS = 9'h040;
    localparam logic [8:0] CW_OPC = 9'h080;
    localparam logic [8:0] CW_H   = 9'h100;

    logic            clk = 1'b0;
    logic            reset;
    logic [MIW-1:0]  microinst;
    logic            stall, n, z, mem_req, mem_we, mem_fetch, mem_ack;
    logic [31:0]     mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mic_datapath_stall dut (
        .clk       (clk),
        .reset     (reset),
        .microinst (microinst),
        .stall     (stall),
        .n         (n),
        .z         (z),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_fetch (mem_fetch),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Reference model: register array, MBR, flags, and a queue of pending memory ops
    typedef struct {
        logic        fetch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    op_t         pend[$];
    logic [31:0] r[9];      // index = C-bus bit: MAR MDR PC SP LV CPP TOS OPC H
    logic [7:0]  mbr;
    logic        fn_q, fz_q;
    logic        last_stall;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    logic [5:0]  fn_tab[16] = '{6'b011000, 6'b010100, 6'b011010, 6'b101100,
                                6'b111100, 6'b111101, 6'b111001, 6'b110101,
                                6'b111111, 6'b110110, 6'b111011, 6'b001100,
                                6'b011100, 6'b010000, 6'b110001, 6'b110010};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [MIW-1:0] mk(input logic [1:0] sh, input logic [5:0] f,
                                          input logic [8:0] cw, input logic [2:0] mem,
                                          input logic [3:0] bs);
        logic [MIW-1:0] m;
        m = '0;
        m[MI_SHIFT_LSB +: 2] = sh;
        m[MI_ALU_LSB +: 6]   = f;
        m[MI_CWR_LSB +: 9]   = cw;
        m[MI_MEM_LSB +: 3]   = mem;
        m[MI_BSEL_LSB +: 4]  = bs;
        return m;
    endfunction

    // Named Mic-1 ALU functions with A=H and B=B-bus
    function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        case (f)
            6'b011000: return a;
            6'b010100: return b;
            6'b011010: return ~a;
            6'b101100: return ~b;
            6'b111100: return a + b;
            6'b111101: return a + b + 32'd1;
            6'b111001: return a + 32'd1;
            6'b110101: return b + 32'd1;
            6'b111111: return b - a;
            6'b110110: return b - 32'd1;
            6'b111011: return 32'd0 - a;
            6'b001100: return a & b;
            6'b011100: return a | b;
            6'b010000: return 32'd0;
            6'b110001: return 32'd1;
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] ref_b(input logic [3:0] bs);
        case (bs)
            4'd0: return r[1];
            4'd1: return r[2];
            4'd2: return {{24{mbr[7]}}, mbr};
            4'd3: return {24'd0, mbr};
            4'd4: return r[3];
            4'd5: return r[4];
            4'd6: return r[5];
            4'd7: return r[6];
            4'd8: return r[7];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_shift(input logic [1:0] sh, input logic [31:0] v);
        logic [31:0] t;
        t = sh[1] ? v * 32'd256 : v;
        if (sh[0]) t = $unsigned($signed(t) / 2 - (($signed(t) < 0 && t[0]) ? 1 : 0));
        return t;
    endfunction

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < 9; i++) r[i] = 32'd0;
        mbr  = 8'd0;
        fn_q = 1'b0;
        fz_q = 1'b0;
        last_stall = 1'b0;
    endtask

    // One clock: drive, compare outputs against the model, then advance the model
    task automatic step(input logic [MIW-1:0] mi, input logic ack, input logic [31:0] rdata,
                        input logic rst);
        logic [1:0]  sh;
        logic [5:0]  f;
        logic [8:0]  cw;
        logic        wr, rd, fe, busy, stl, e_we, e_fe;
        logic [3:0]  bs;
        logic [31:0] alu, res;
        op_t         o;
        @(negedge clk);
        microinst = mi;
        mem_ack   = ack;
        mem_rdata = rdata;
        reset     = rst;
        #1;
        sh = mi[MI_SHIFT_LSB +: 2];
        f  = mi[MI_ALU_LSB +: 6];
        cw = mi[MI_CWR_LSB +: 9];
        wr = mi[MI_MEM_LSB + 2];
        rd = mi[MI_MEM_LSB + 1];
        fe = mi[MI_MEM_LSB];
        bs = mi[MI_BSEL_LSB +: 4];
        busy = (pend.size() != 0);
        stl  = busy && (wr || rd || fe || bs == 4'd0 || bs == 4'd2 || bs == 4'd3 ||
                        cw[0] || cw[1] || cw[2]);
        e_we = 1'b0;
        e_fe = 1'b0;
        if (busy) begin
            e_fe = pend[0].fetch;
            e_we = !pend[0].fetch && pend[0].we;
        end
        check("stall", 32'(stall), 32'(stl));
        check("mem_req", 32'(mem_req), 32'(busy));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_fetch", 32'(mem_fetch), 32'(e_fe));
        if (busy) check("mem_addr", mem_addr, pend[0].addr);
        if (e_we) check("mem_wdata", mem_wdata, pend[0].wdata);
        check("n", 32'(n), 32'(fn_q));
        check("z", 32'(z), 32'(fz_q));
        last_stall = stl;
        if (rst) begin
            model_reset();
        end else begin
            if (!stl) begin
                alu = ref_alu(f, r[8], ref_b(bs));
                res = ref_shift(sh, alu);
                for (int i = 0; i < 9; i++) if (cw[i]) r[i] = res;
                fn_q = alu[31];
                fz_q = (alu == 32'd0);
                if (!busy) begin
                    if (wr || rd) pend.push_back('{fetch: 1'b0, we: wr, addr: r[0], wdata: r[1]});
                    if (fe)       pend.push_back('{fetch: 1'b1, we: 1'b0, addr: r[2], wdata: 32'd0});
                end
            end
            if (busy && ack) begin
                o = pend.pop_front();
                if (o.fetch)     mbr  = rdata[7:0];
                else if (!o.we)  r[1] = rdata;
            end
        end
    endtask

    function automatic logic [MIW-1:0] nop();
        return mk(2'b00, ALU_FN_ZERO, 9'd0, 3'b000, 4'd9);
    endfunction

    task automatic drain();
        for (int k = 0; k < 4 && pend.size() != 0; k++) step(nop(), 1'b1, $urandom, 1'b0);
    endtask

    // Bring a value in through MDR with a read, then move it to the target registers
    task automatic load_reg(input logic [8:0] cw, input logic [31:0] val);
        drain();
        step(mk(2'b00, ALU_FN_ZERO, 9'd0, M_RD, 4'd9), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b1, val, 1'b0);
        step(mk(2'b00, ALU_FN_B, cw, 3'b000, 4'd0), 1'b0, 32'd0, 1'b0);
    endtask

    function automatic logic [MIW-1:0] rand_mi();
        logic [1:0] sh;
        logic [2:0] mem;
        sh  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        mem = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
        return mk(sh, fn_tab[$urandom_range(0, 15)], 9'($urandom & $urandom), mem,
                  4'($urandom_range(0, 15)));
    endfunction

    initial begin
        logic [MIW-1:0] cur, dep;
        logic           ack;
        reset     = 1'b1;
        microinst = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, then reset in the middle of a read followed by a stray ack
        step(nop(), 1'b0, 32'd0, 1'b0);
        step(mk(2'b00, ALU_FN_ONE, CW_MDR, M_RD, 4'd9), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b0, 32'd0, 1'b1);
        step(nop(), 1'b1, 32'hCAFE_F00D, 1'b0);
        step(mk(2'b00, ALU_FN_ZERO, 9'd0, M_WR, 4'd9), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b1, 32'd0, 1'b0);

        // A+B into OPC, then B-A giving zero
        load_reg(CW_H, 32'd5);
        load_reg(CW_TOS, 32'd3);
        step(mk(2'b00, ALU_FN_A_ADD_B, CW_OPC, 3'b000, 4'd7), 1'b0, 32'd0, 1'b0);
        step(mk(2'b00, ALU_FN_B, CW_MDR, M_WR, 4'd8), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b1, 32'd0, 1'b0);
        load_reg(CW_H, 32'd3);
        step(mk(2'b00, ALU_FN_B_SUB_A, 9'd0, 3'b000, 4'd7), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b0, 32'd0, 1'b0);

        // Read at 0x10 with a dependent MDR consumer held until the ack
        load_reg(CW_MAR, 32'h10);
        step(mk(2'b00, ALU_FN_ZERO, 9'd0, M_RD, 4'd9), 1'b0, 32'd0, 1'b0);
        dep = mk(2'b00, ALU_FN_B, CW_H, 3'b000, 4'd0);
        step(dep, 1'b0, 32'd0, 1'b0);
        step(dep, 1'b0, 32'd0, 1'b0);
        step(dep, 1'b1, 32'hDEAD_BEEF, 1'b0);
        step(dep, 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b0, 32'd0, 1'b0);

        // Read plus fetch from PC=7, then MBR sign/zero extension
        load_reg(CW_PC, 32'd7);
        step(mk(2'b00, ALU_FN_ZERO, 9'd0, M_RD | M_FE, 4'd9), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b1, 32'h1234_5678, 1'b0);
        step(nop(), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b1, 32'h0000_0080, 1'b0);
        step(mk(2'b00, ALU_FN_B, CW_H, 3'b000, 4'd2), 1'b0, 32'd0, 1'b0);
        step(mk(2'b00, ALU_FN_B, CW_H, 3'b000, 4'd3), 1'b0, 32'd0, 1'b0);
        step(mk(2'b00, ALU_FN_A, CW_MDR, M_WR, 4'd9), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b1, 32'd0, 1'b0);

        // Write busy: SP update proceeds, MAR update stalls until ack
        load_reg(CW_TOS, 32'h0000_0ABC);
        step(mk(2'b00, ALU_FN_ZERO, 9'd0, M_WR, 4'd9), 1'b0, 32'd0, 1'b0);
        step(mk(2'b00, ALU_FN_B, CW_SP, 3'b000, 4'd7), 1'b0, 32'd0, 1'b0);
        dep = mk(2'b00, ALU_FN_ONE, CW_MAR, 3'b000, 4'd9);
        step(dep, 1'b0, 32'd0, 1'b0);
        step(dep, 1'b1, 32'd0, 1'b0);
        step(dep, 1'b0, 32'd0, 1'b0);

        // Both shifts on 0x81, then wr+rd together is a write that leaves MDR alone
        load_reg(CW_H, 32'h0000_0081);
        step(mk(2'b11, ALU_FN_A, CW_TOS, 3'b000, 4'd9), 1'b0, 32'd0, 1'b0);
        step(mk(2'b00, ALU_FN_B, CW_MDR, M_WR | M_RD, 4'd7), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b1, 32'h0BAD_0BAD, 1'b0);
        step(mk(2'b00, ALU_FN_ZERO, 9'd0, M_WR, 4'd9), 1'b0, 32'd0, 1'b0);
        step(nop(), 1'b1, 32'd0, 1'b0);

        // Random microinstructions against a random-latency memory
        cur = nop();
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall || $urandom_range(0, 7) == 0) cur = rand_mi();
            ack = (pend.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            step(cur, ack, $urandom, ($urandom_range(0, 599) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
